// File: rtl/dcache_controller.sv
// dcache_controller
//   Direct-mapped, write-back, write-allocate L1 data cache controller for the
//   MEM stage. Loads and stores hit with zero added latency. A miss raises
//   p1_stall_o combinationally and runs the refill FSM:
//   IDLE -> MISS -> (WRITEBACK) -> READMISS -> READMISSOK -> IDLE.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   p1_addr_i           CPU byte address: [4:2] word, [5+IW-1:5] index, [31:5+IW] tag
//   p1_data_i           store data
//   p1_MemRead_i/Write  load / store request (store wins if both are set)
//   p1_data_o           load data, combinational from the indexed line
//   p1_stall_o          high while the request has not completed
//   mem_enable_o        memory request valid (WRITEBACK, READMISS)
//   mem_write_o         1 = line write-back, 0 = line fill
//   mem_addr_o          line-aligned memory address
//   mem_data_o          write-back line data
//   mem_data_i          fill line data, valid with mem_ack_i
//   mem_ack_i           single-cycle memory completion pulse
module dcache_controller #(
  parameter int LINES     = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          p1_addr_i,
  input  logic [31:0]          p1_data_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 32 - 5 - IW;

  typedef enum logic [2:0] {
    S_IDLE, S_MISS, S_WRITEBACK, S_READMISS, S_READMISSOK
  } state_t;

  state_t r_state, w_next;

  logic [LINES-1:0]     r_valid;
  logic [LINES-1:0]     r_dirty;
  logic [TW-1:0]        r_tag  [LINES];
  logic [LINE_BITS-1:0] r_data [LINES];

  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic [2:0]    w_off;
  logic          w_req, w_hit, w_wr_hit, w_fill;
  logic          w_unused;

  assign w_idx    = p1_addr_i[5+IW-1:5];
  assign w_tag    = p1_addr_i[31:5+IW];
  assign w_off    = p1_addr_i[4:2];
  assign w_unused = &{1'b0, p1_addr_i[1:0]};

  assign w_req    = p1_MemRead_i | p1_MemWrite_i;
  assign w_hit    = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  // A store with read also asserted is still a store; the hit check gates it.
  assign w_wr_hit = p1_MemWrite_i & w_hit;
  // The fill address is the CPU address, which the CPU holds during the stall.
  assign w_fill   = (r_state == S_READMISS) & mem_ack_i;

  assign p1_stall_o = w_req & ~w_hit;
  assign p1_data_o  = r_data[w_idx][{w_off, 5'b0} +: 32];

  // State and line-status bits; these are the only state that needs reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_next;
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end else if (w_wr_hit) begin
        r_dirty[w_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset: valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (w_fill) begin
      r_data[w_idx] <= mem_data_i;
      r_tag[w_idx]  <= w_tag;
    end else if (w_wr_hit) begin
      r_data[w_idx][{w_off, 5'b0} +: 32] <= p1_data_i;
    end
  end

  always_comb begin
    w_next       = r_state;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (r_state)
      S_IDLE:       if (w_req & ~w_hit) w_next = S_MISS;
      S_MISS:       w_next = (r_valid[w_idx] & r_dirty[w_idx]) ? S_WRITEBACK : S_READMISS;
      S_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {r_tag[w_idx], w_idx, 5'b0};
        mem_data_o   = r_data[w_idx];
        if (mem_ack_i) w_next = S_READMISS;
      end
      S_READMISS: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {w_tag, w_idx, 5'b0};
        if (mem_ack_i) w_next = S_READMISSOK;
      end
      S_READMISSOK: w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: a memory responder pops expected line requests
// from a scoreboard queue, checks them and holds them until a per-request
// ack delay expires; the main sequence drives CPU accesses and checks
// stall latency and load data against constants and a backing-store model.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_addr_i, p1_data_i;
  logic         p1_MemRead_i, p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  dcache_controller #(.LINES(32), .LINE_BITS(256)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit           w;
    logic [31:0]  a;
    logic [255:0] d;
    int           dly;
  } mreq_t;

  mreq_t        sb_q[$];
  logic [255:0] mem_store [bit [31:0]];
  int           n_vec = 0, n_err = 0;
  int           n_req = 0;
  int           spur_cnt = 0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] pat_line(input logic [31:0] la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = la + 32'(k*4) + 32'h1000_0000;
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    if (mem_store.exists(la)) return mem_store[la];
    return pat_line(la);
  endfunction

  task automatic push_req(input bit w, input logic [31:0] a, input logic [255:0] d, input int dly);
    mreq_t e;
    e.w = w; e.a = a; e.d = d; e.dly = dly;
    sb_q.push_back(e);
  endtask

  // Memory responder
  initial begin : responder
    int    spur_seen;
    mreq_t e;
    bit    aborted;
    spur_seen = 0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (mem_enable_o && !rst_i) begin
        n_req++;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else begin
          chk("sb_unexpected_req", 1, 0);
          e.w = mem_write_o; e.a = mem_addr_o; e.d = mem_data_o; e.dly = 1;
        end
        chk("sb_write", mem_write_o, e.w);
        chk("sb_addr", mem_addr_o, e.a);
        if (e.w) chk("sb_wdata", mem_data_o, e.d);
        aborted = 1'b0;
        for (int k = 1; k < e.dly; k++) begin
          @(negedge clk_i);
          if (rst_i) begin aborted = 1'b1; break; end
          chk("hold_en", mem_enable_o, 1);
          chk("hold_wr", mem_write_o, e.w);
          chk("hold_addr", mem_addr_o, e.a);
          if (e.w) chk("hold_data", mem_data_o, e.d);
        end
        if (aborted) begin
          repeat (2) @(negedge clk_i);
          mem_ack_i = 1'b1;
          mem_data_i = {8{32'hBAD0_BAD0}};
        end else begin
          mem_ack_i = 1'b1;
          if (e.w) begin
            mem_store[e.a] = mem_data_o;
            mem_data_i = '0;
          end else begin
            mem_data_i = mem_line(e.a);
          end
        end
      end else if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        mem_ack_i = 1'b1;
        mem_data_i = '1;
      end
    end
  end

  task automatic do_acc(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output int cyc, output logic [31:0] q);
    @(negedge clk_i);
    p1_addr_i = a; p1_data_i = d; p1_MemRead_i = rd; p1_MemWrite_i = wr;
    #1;
    cyc = 0;
    while (p1_stall_o && cyc < 200) begin
      @(negedge clk_i); #1;
      cyc++;
    end
    if (p1_stall_o) chk("acc_timeout", 1, 0);
    q = p1_data_o;
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    @(negedge clk_i);
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int           cyc, n0, t;
    logic [31:0]  q;
    logic [255:0] l;

    rst_i = 1'b1;
    p1_addr_i = '0; p1_data_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    l = pat_line(32'h100);
    l[63:32] = 32'hDEAD_BEEF;
    mem_store[32'h100] = l;
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b0;
    @(negedge clk_i); #1;
    chk("rst_stall", p1_stall_o, 0);
    chk("rst_mem_en", mem_enable_o, 0);
    chk("rst_mem_wr", mem_write_o, 0);

    // Cold read miss
    push_req(0, 32'h100, '0, 4);
    do_acc(1, 0, 32'h104, 0, cyc, q);
    chk("cold_lat", cyc, 6);
    chk("cold_data", q, 32'hDEAD_BEEF);
    n0 = n_req;
    do_acc(1, 0, 32'h104, 0, cyc, q);
    chk("rehit_lat", cyc, 0);
    chk("rehit_data", q, 32'hDEAD_BEEF);
    chk("rehit_no_mem", n_req, n0);

    // Write hit then eviction
    do_acc(0, 1, 32'h104, 32'h1234_5678, cyc, q);
    chk("wrhit_lat", cyc, 0);
    do_acc(1, 0, 32'h104, 0, cyc, q);
    chk("wrhit_data", q, 32'h1234_5678);
    do_acc(1, 0, 32'h100, 0, cyc, q);
    chk("wrhit_other_word", q, 32'h1000_0100);
    l = mem_line(32'h100);
    l[63:32] = 32'h1234_5678;
    push_req(1, 32'h100, l, 4);
    push_req(0, 32'h500, '0, 4);
    do_acc(1, 0, 32'h504, 0, cyc, q);
    chk("evict_lat", cyc, 10);
    chk("evict_data", q, 32'h1000_0504);

    // Write miss allocate (index 0, clean)
    push_req(0, 32'h2000, '0, 4);
    do_acc(0, 1, 32'h2008, 32'hCAFE_F00D, cyc, q);
    chk("wmiss_lat", cyc, 6);
    do_acc(1, 0, 32'h2008, 0, cyc, q);
    chk("wmiss_hit_lat", cyc, 0);
    chk("wmiss_data", q, 32'hCAFE_F00D);
    do_acc(1, 0, 32'h2000, 0, cyc, q);
    chk("wmiss_word0", q, 32'h1000_2000);
    l = pat_line(32'h2000);
    l[95:64] = 32'hCAFE_F00D;
    push_req(1, 32'h2000, l, 4);
    push_req(0, 32'h0000, '0, 4);
    do_acc(1, 0, 32'h0008, 0, cyc, q);
    chk("wmiss_evict_lat", cyc, 10);
    chk("wmiss_evict_data", q, 32'h1000_0008);

    // Handshake hold: long write-back ack delay
    do_acc(0, 1, 32'h0008, 32'h55AA_1234, cyc, q);
    chk("hold_wrhit_lat", cyc, 0);
    l = pat_line(32'h0000);
    l[95:64] = 32'h55AA_1234;
    push_req(1, 32'h0000, l, 10);
    push_req(0, 32'h0400, '0, 3);
    n0 = n_req;
    do_acc(1, 0, 32'h0408, 0, cyc, q);
    chk("hold_lat", cyc, 15);
    chk("hold_data_out", q, 32'h1000_0408);
    chk("hold_req_count", n_req - n0, 2);

    // Spurious ack with no request
    idle();
    n0 = n_req;
    spur_cnt++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i); #1;
      chk("spur_stall", p1_stall_o, 0);
      chk("spur_mem_en", mem_enable_o, 0);
    end
    do_acc(1, 0, 32'h504, 0, cyc, q);
    chk("spur_hit_lat", cyc, 0);
    chk("spur_hit_data", q, 32'h1000_0504);
    chk("spur_no_mem", n_req, n0);

    // Reset during READMISS
    push_req(0, 32'h00C0, '0, 8);
    @(negedge clk_i);
    p1_addr_i = 32'h00C0; p1_MemRead_i = 1'b1; p1_MemWrite_i = 1'b0;
    #1;
    for (t = 0; t < 20 && !mem_enable_o; t++) begin @(negedge clk_i); #1; end
    chk("rm_reached", mem_enable_o, 1);
    chk("rm_is_fill", mem_write_o, 0);
    @(posedge clk_i); #2 rst_i = 1'b1;
    @(posedge clk_i); #2 rst_i = 1'b0;
    p1_MemRead_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i); #1;
      chk("postrst_mem_en", mem_enable_o, 0);
      chk("postrst_mem_wr", mem_write_o, 0);
      chk("postrst_stall", p1_stall_o, 0);
    end
    @(negedge clk_i);
    p1_addr_i = 32'h0504; p1_MemRead_i = 1'b1;
    #1 chk("postrst_old_misses", p1_stall_o, 1);
    p1_addr_i = 32'h00C0;
    #1 chk("postrst_late_ack_ignored", p1_stall_o, 1);
    p1_MemRead_i = 1'b0;
    push_req(0, 32'h00C0, '0, 2);
    do_acc(1, 0, 32'h00C0, 0, cyc, q);
    chk("postrst_fill_lat", cyc, 4);
    chk("postrst_fill_data", q, 32'h1000_00C0);
    idle();

    repeat (3) @(negedge clk_i);
    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
